fsm_context_scheduler: RTL
==========================

Name: fsm_context_scheduler

Overview:
- Shares one x/y sequence-detector next-state engine among N requester channels.
- Keeps a 2-bit state context per channel and grants the engine to one channel per cycle.
- Arbitration is round-robin with bounded bursts.
- Sits between N independent serial x/y sources and their per-channel z flags, replacing N separate detector instances.

Parameters:
- N, 4, number of requester channels (2..8, power of two); CW = clog2(N) is a derived localparam.
- BURST, 4, maximum consecutive steps granted to one channel before rotation (1..15).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- req  input  N  per-channel step request; held high while x/y are valid.
- x  input  N  per-channel x input; sampled only on that channel's step edge.
- y  input  N  per-channel y input; sampled only on that channel's step edge.
- clr  input  N  per-channel synchronous context clear to S0.
- gnt  output  N  registered one-hot (or zero) grant.
- z  output  N  per-channel flag; 1 when that context is in S2 or S3.
- step_valid  output  1  registered pulse: a step was applied at the previous edge.
- step_ch  output  CW  channel index of the step reported by step_valid.

Behaviour:
- Reset (reset_b=0, async):
  - all contexts = S0, so z = 0.
  - gnt = 0, step_valid = 0, step_ch = 0.
  - burst counter = 0.
  - round-robin pointer = N-1, so channel 0 has first priority.
- Context encoding: S0=00, S1=01, S2=10, S3=11. z[i] is a combinational decode of ctx[i] (ctx[i][1]).
- Step condition: a step occurs at an edge when gnt[i]=1 and req[i]=1. ctx[i] is then updated from the current x[i], y[i]:
  - S0: x=0 -> S0; x=1,y=0 -> S3; x=1,y=1 -> S1.
  - S1: x=0 -> S0; else S2.
  - S2: x=0 -> S0; else S3.
  - S3: x=0 -> S0; else S3.
- No step condition: if gnt[i]=1 and req[i]=0, no step is taken and ctx[i] holds.
- step_valid / step_ch: after a step edge, step_valid=1 and step_ch=i. In the same cycle, z[i] already shows the updated context. step_valid=0 otherwise.
- Arbiter states:
  - IDLE (gnt=0).
  - GRANT(i) with burst counter cnt.
- Arbiter transitions, evaluated at each edge:
  - IDLE: pick the first requester after the pointer in ascending cyclic order; gnt <= that channel, cnt <= 0. No requesters -> stay IDLE.
  - GRANT(i), step taken, cnt+1 < BURST: stay on i, cnt++.
  - GRANT(i), step taken, cnt+1 == BURST: pointer <= i, then re-arbitrate in the same edge with no bubble. The next requester may be i itself if it is the only one; cnt restarts at 0.
  - GRANT(i), req[i]=0: pointer <= i, re-arbitrate the same way, or go to IDLE if no requests.
- Grant latency: req rising in IDLE -> gnt one edge later -> first step at the following edge.
- clr[i]: ctx[i] <= S0 at the edge.
  - clr has priority over a simultaneous step on the same channel: the step is discarded, step_valid=0, and the burst count is still consumed.
  - clr never affects arbitration.
- Unselected channels: contexts hold indefinitely; x/y of non-granted channels are ignored.
- Async reset mid-burst: all state returns immediately to the reset values above; no partial step is retained.

Test Plan:
- Reset: assert reset_b=0 mid-activity -> gnt=0, z=0, step_valid=0, step_ch=0 immediately; after release with req=0001, gnt=0001 at the next edge.
- Single channel, BURST=4: req0=1, x0=1, y0=1 for 3 steps -> ctx0 goes S1, S2, S3; z0 = 0, 1, 1; step_valid=1 with step_ch=0 each cycle after the first grant.
- Round-robin, BURST=1: req=1111 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles with no bubbles.
- Burst: BURST=4, req=0101 -> gnt0 for 4 cycles, then gnt2 for 4 cycles, then gnt0; dropping req0 after 2 steps -> gnt moves to channel 2 at the next edge.
- Context isolation: drive ch1 with x=1, y=0 -> z1=1 (S3); run ch2 with x=0 for 6 steps -> z1 stays 1; then ch1 step with x=0 -> z1=0.
- clr collision: clr2=1 on the edge of a granted ch2 step from S2 -> ctx2=S0, z2=0, step_valid=0; clr on an idle channel in S3 -> S0 with no grant change.

Source files
------------

// File: rtl/fsm_context_scheduler.sv
// Time-shared x/y sequence-detector engine: one 2-bit context per channel,
// a round-robin arbiter with bounded bursts picks which channel steps each cycle.
module fsm_context_scheduler #(
  parameter int  N     = 4,
  parameter int  BURST = 4,
  localparam int CW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  x,
  input  logic [N-1:0]  y,
  input  logic [N-1:0]  clr,
  output logic [N-1:0]  gnt,
  output logic [N-1:0]  z,
  output logic          step_valid,
  output logic [CW-1:0] step_ch
);

  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} ctx_e;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_e;

  ctx_e          ctx_q [N];
  ctx_e          ctx_d [N];
  arb_e          arb_q, arb_d;
  logic [CW-1:0] gnt_ch_q, gnt_ch_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          step_valid_q, step_valid_d;
  logic [CW-1:0] step_ch_q, step_ch_d;
  logic          step;
  logic [CW:0]   pick_res;

  function automatic ctx_e next_ctx(input ctx_e c, input logic xi, input logic yi);
    if (!xi) return S0;
    case (c)
      S0:      return yi ? S1 : S3;
      S1:      return S2;
      default: return S3;
    endcase
  endfunction

  // First requester strictly after p in cyclic order; p itself is checked last.
  function automatic logic [CW:0] pick(input logic [N-1:0] r, input logic [CW-1:0] p);
    logic [CW-1:0] idx;
    pick = '0;
    for (int k = N; k >= 1; k--) begin
      idx = p + CW'(k);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    arb_d        = arb_q;
    gnt_ch_d     = gnt_ch_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    ctx_d        = ctx_q;
    step_valid_d = 1'b0;
    step_ch_d    = step_ch_q;
    step         = (arb_q == ARB_GRANT) && req[gnt_ch_q];
    pick_res     = pick(req, ptr_q);

    case (arb_q)
      ARB_IDLE: begin
        if (pick_res[CW]) begin
          arb_d    = ARB_GRANT;
          gnt_ch_d = pick_res[CW-1:0];
          cnt_d    = '0;
        end
      end
      default: begin
        if (step && (32'(cnt_q) + 1) < BURST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          // Burst exhausted or requester dropped: rotate with no idle bubble.
          ptr_d    = gnt_ch_q;
          pick_res = pick(req, gnt_ch_q);
          cnt_d    = '0;
          if (pick_res[CW]) gnt_ch_d = pick_res[CW-1:0];
          else              arb_d    = ARB_IDLE;
        end
      end
    endcase

    for (int i = 0; i < N; i++) begin
      if (clr[i])                                ctx_d[i] = S0;
      else if (step && (gnt_ch_q == CW'(i)))     ctx_d[i] = next_ctx(ctx_q[i], x[i], y[i]);
    end

    // A clear on the stepping channel discards the step but the burst slot is still spent.
    if (step && !clr[gnt_ch_q]) begin
      step_valid_d = 1'b1;
      step_ch_d    = gnt_ch_q;
    end

    gnt_d = '0;
    if (arb_d == ARB_GRANT) gnt_d[gnt_ch_d] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      arb_q        <= ARB_IDLE;
      gnt_ch_q     <= '0;
      ptr_q        <= CW'(N - 1);
      cnt_q        <= '0;
      gnt_q        <= '0;
      step_valid_q <= 1'b0;
      step_ch_q    <= '0;
      // NOTE: the context array is tiny and must read S0 after reset, so it is reset like any flop.
      for (int i = 0; i < N; i++) ctx_q[i] <= S0;
    end else begin
      arb_q        <= arb_d;
      gnt_ch_q     <= gnt_ch_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      step_valid_q <= step_valid_d;
      step_ch_q    <= step_ch_d;
      for (int i = 0; i < N; i++) ctx_q[i] <= ctx_d[i];
    end
  end

  always_comb begin
    z = '0;
    for (int i = 0; i < N; i++) z[i] = ctx_q[i][1];
  end

  assign gnt        = gnt_q;
  assign step_valid = step_valid_q;
  assign step_ch    = step_ch_q;

endmodule
